// File: rtl/rover_switch_input_ctrl.sv
// -----------------------------------------------------------------------------
// rover_switch_input_ctrl
//
// Purpose:
//   Input stage for the rover's slide switches. Each raw switch is passed
//   through a 2-flop synchroniser and then debounced: a new level is accepted
//   only after it has persisted for DEBOUNCE_CYCLES consecutive clocks. The
//   debounced word is published to consumers through a valid/ack handshake.
//   A sticky change mask records which bits moved since the last ack. One
//   debounced channel drives end_reset, which releases the downstream reset
//   hold. Per-channel status LEDs are also driven.
//
// Build option:
//   LED_BLINK_EN - when defined, a channel whose synchronised input disagrees
//                  with its debounced level shows a blinking LED (half period
//                  BLINK_CYCLES). When undefined, led is a registered copy of
//                  the debounced word and BLINK_CYCLES is not used.
//
// Ports:
//   clk          in   1       system clock, rising edge
//   reset        in   1       asynchronous assert, active-high reset
//   sw           in   NUM_SW  raw switch levels (asynchronous to clk)
//   state        out  NUM_SW  debounced switch word for consumers
//   state_valid  out  1       a new state word awaits consumption
//   state_ack    in   1       consumer accepts the current word
//   changed_mask out  NUM_SW  bits changed since the last ack (sticky)
//   end_reset    out  1       debounced level of sw[END_RESET_IDX]
//   led          out  NUM_SW  per-channel status LEDs
// -----------------------------------------------------------------------------
module rover_switch_input_ctrl #(
  parameter int NUM_SW          = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int END_RESET_IDX   = NUM_SW - 1,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw,
  output logic [NUM_SW-1:0] state,
  output logic              state_valid,
  input  logic              state_ack,
  output logic [NUM_SW-1:0] changed_mask,
  output logic              end_reset,
  output logic [NUM_SW-1:0] led
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject unusable configurations at elaboration time.
  if (NUM_SW < 1 || NUM_SW > 32 || DEBOUNCE_CYCLES < 2 ||
      END_RESET_IDX < 0 || END_RESET_IDX >= NUM_SW || BLINK_CYCLES < 2) begin : g_bad_param
    $error("rover_switch_input_ctrl: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // 2-flop synchroniser
  // ---------------------------------------------------------------------------
  logic [NUM_SW-1:0] sync_meta_reg;
  logic [NUM_SW-1:0] sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta_reg <= '0;
      sync_reg      <= '0;
    end else begin
      sync_meta_reg <= sw;
      sync_reg      <= sync_meta_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce: counter runs only while the synchronised level
  // disagrees with the accepted level, and saturates at acceptance, so it
  // can never wrap.
  // ---------------------------------------------------------------------------
  logic [NUM_SW-1:0] stable;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SW; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic             stable_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else if (sync_reg[gi] == stable_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          stable_reg <= sync_reg[gi];
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign stable[gi] = stable_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Change handshake
  // ---------------------------------------------------------------------------
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } hs_state_t;

  hs_state_t         hs_reg, hs_next;
  logic [NUM_SW-1:0] state_reg, state_next;
  logic [NUM_SW-1:0] mask_reg, mask_next;
  logic [NUM_SW-1:0] diff;

  assign diff = stable ^ state_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_reg    <= IDLE;
      state_reg <= '0;
      mask_reg  <= '0;
    end else begin
      hs_reg    <= hs_next;
      state_reg <= state_next;
      mask_reg  <= mask_next;
    end
  end

  always_comb begin
    hs_next    = hs_reg;
    state_next = state_reg;
    mask_next  = mask_reg;
    case (hs_reg)
      IDLE: begin
        if (|diff) begin
          state_next = stable;
          mask_next  = diff;
          hs_next    = PENDING;
        end
      end
      PENDING: begin
        if (|diff) begin
          // A change arriving with the ack starts a fresh mask so the new
          // word is reported on its own and is never lost.
          state_next = stable;
          mask_next  = state_ack ? diff : (mask_reg | diff);
        end else if (state_ack) begin
          mask_next = '0;
          hs_next   = IDLE;
        end
      end
    endcase
  end

  // end_reset is registered alongside state so both move on the same edge.
  logic end_reset_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      end_reset_reg <= 1'b0;
    end else begin
      end_reset_reg <= stable[END_RESET_IDX];
    end
  end

  // ---------------------------------------------------------------------------
  // Status LEDs
  // ---------------------------------------------------------------------------
  logic [NUM_SW-1:0] led_reg;

`ifdef LED_BLINK_EN
  localparam int               BLK_W   = $clog2(BLINK_CYCLES);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_CYCLES - 1);

  logic [BLK_W-1:0] blink_cnt_reg;
  logic             blink_phase_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (blink_cnt_reg == BLK_MAX) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= ~blink_phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BLK_W'(1);
    end
  end

  // A channel that is currently debouncing shows the blink phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        led_reg[i] <= (sync_reg[i] == stable[i]) ? stable[i] : blink_phase_reg;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_reg <= '0;
    end else begin
      led_reg <= stable;
    end
  end
`endif

  assign state        = state_reg;
  assign state_valid  = (hs_reg == PENDING);
  assign changed_mask = mask_reg;
  assign end_reset    = end_reset_reg;
  assign led          = led_reg;

endmodule
